mc_rd_scheduler: RTL
====================

Name: mc_rd_scheduler

Overview:
Shares the single latency-1 read port of the multichannel buffer memory among NUM_CH channel readers. Each cycle it picks one eligible channel using round-robin with a configurable burst hold, and issues the memory read. It tags the read and routes the returned word, one cycle later, to the granted channel. Each channel output feeds its own latency-1-to-0 prefetch adapter.

Parameters:
NUM_CH, 4, number of requesting channels (2..16)
WIDTH, 32, read data width
BURST_LEN, 2, maximum consecutive grants to one channel before rotating (1..15)
CH_W, $clog2(NUM_CH), channel index width (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
sched_en  in  1  global enable; 0 blocks all new grants, outstanding return still delivered
ch_req  in  NUM_CH  per-channel read request (level)
ch_empty  in  NUM_CH  per-channel buffer-empty flag from occupancy logic
ch_gnt  out  NUM_CH  one-hot grant, same cycle as mem_rd_en
ch_rd_valid  out  NUM_CH  one-hot return strobe to the owning channel
ch_rd_data  out  WIDTH  returned data, shared bus, qualified by ch_rd_valid
mem_rd_en  out  1  read strobe to buffer memory
mem_rd_ch  out  CH_W  channel index of the read
mem_rd_valid  in  1  memory return valid, exactly 1 cycle after mem_rd_en
mem_rd_data  in  WIDTH  memory return data
err_protocol  out  1  sticky: return without outstanding read, or missing return

Behaviour:
- Reset values: ch_gnt=0, ch_rd_valid=0, mem_rd_en=0, mem_rd_ch=0, err_protocol=0, rr_ptr=0, burst_cnt=0, cur_ch=0, tag_vld_q=0, tag_q=0.
- eligible[i] = sched_en & ch_req[i] & ~ch_empty[i].
- Grant is combinational from eligible and registered state, so issue latency is 0 cycles. At most one grant per cycle. mem_rd_en = |ch_gnt. mem_rd_ch = index of ch_gnt; it holds its last value when idle.
- Arbitration FSM states:
  - IDLE: no grant last cycle.
  - HOLD: cur_ch was granted last cycle and burst_cnt < BURST_LEN.
- In HOLD, if eligible[cur_ch], grant cur_ch again and increment burst_cnt.
- Otherwise, grant the first eligible channel scanning from rr_ptr upward with wrap (rr_ptr..NUM_CH-1, 0..rr_ptr-1). Set cur_ch to that channel, burst_cnt=1, rr_ptr=(winner+1) mod NUM_CH.
- When burst_cnt reaches BURST_LEN, the next cycle arbitrates normally from rr_ptr, which already points past cur_ch. Any other eligible channel then wins. If cur_ch is the only eligible channel, it wins again with burst_cnt=1.
- No eligible channel: no grant, state goes to IDLE, rr_ptr and burst_cnt unchanged.
- BURST_LEN=1 gives pure round-robin.
- Return path:
  - On grant, tag_q<=winner and tag_vld_q<=1; otherwise tag_vld_q<=0.
  - ch_rd_valid = mem_rd_valid & tag_vld_q ? onehot(tag_q) : 0.
  - ch_rd_data = mem_rd_data, passed straight through.
- Back-to-back reads return back-to-back. Grant and return for different channels may occur in the same cycle.
- err_protocol is set on either condition and cleared only by reset:
  - mem_rd_valid & ~tag_vld_q
  - tag_vld_q & ~mem_rd_valid
- Dropping sched_en: a read already issued is still returned and routed.
- Reset mid-operation: all state clears asynchronously and any in-flight return is discarded. The memory shares rst_n, so no return follows reset.
- ch_req falling while a channel is in HOLD simply ends the burst. No request may be lost, and no read is issued for an ineligible channel.

Decomposition:
- Package mc_buf_pkg holds:
  - ch_idx_t typedef (CH_W bits)
  - BURST_CNT_W constant
  - onehot-to-index and index-to-onehot functions
- One sub-module, rr_arbiter: masked round-robin priority pick.
  - Inputs: eligible, rr_ptr.
  - Outputs: one-hot grant and its index.
- Burst/HOLD control, tag pipeline and error logic live in mc_rd_scheduler.

Test Plan:
- NUM_CH=4, BURST_LEN=2; all four ch_req=1, ch_empty=0 for 8 cycles -> grant order 0,0,1,1,2,2,3,3. Each ch_rd_valid pulses 1 cycle after its grant, carrying the memory data (e.g. 0xA0..0xA7).
- Only ch2 eligible, BURST_LEN=2, 5 cycles -> ch2 granted every cycle. burst_cnt sequence is 1,2,1,2,1. No gaps in mem_rd_en.
- ch1 ch_empty=1 while ch_req=1; ch0 and ch3 requesting -> ch1 never granted. Grants alternate between ch0 and ch3 in bursts of 2.
- sched_en dropped in the cycle after a ch0 grant -> no new mem_rd_en, and the outstanding return (0x55) still appears on ch_rd_valid[0].
- mem_rd_valid injected with no preceding grant -> err_protocol=1 next cycle and stays high. It clears only on rst_n.
- rst_n asserted during a burst on ch3 (burst_cnt=1) -> all outputs 0 immediately. The first grant after release goes to ch0 (rr_ptr=0).

Source files
------------

// File: rtl/mc_buf_pkg.sv
// Shared types and helpers for the multichannel buffer read scheduler.
// Index/one-hot helpers work at the maximum channel count; callers size-cast.
package mc_buf_pkg;

    localparam int MAX_CH      = 16;
    localparam int MAX_CH_W    = 4;
    localparam int BURST_CNT_W = 4;

    typedef logic [MAX_CH_W-1:0] ch_idx_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_t;

    function automatic ch_idx_t oh_to_idx(input logic [MAX_CH-1:0] oh);
        ch_idx_t idx;
        idx = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (oh[i]) begin
                idx = idx | ch_idx_t'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [MAX_CH-1:0] idx_to_oh(input ch_idx_t idx);
        logic [MAX_CH-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Masked round-robin pick: lowest eligible channel at or above rr_ptr_i,
// falling back to the lowest eligible channel overall when none is above.
module rr_arbiter
    import mc_buf_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] eligible_i,
    input  logic [CH_W-1:0]   rr_ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [CH_W-1:0]   gnt_idx_o
);

    logic [NUM_CH-1:0] mask_s;
    logic [NUM_CH-1:0] masked_s;
    logic [NUM_CH-1:0] pick_src_s;

    // Thermometer mask of channels at or above the pointer, then isolate lowest set bit.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            mask_s[i] = (CH_W'(i) >= rr_ptr_i);
        end
        masked_s   = eligible_i & mask_s;
        pick_src_s = (|masked_s) ? masked_s : eligible_i;
        gnt_o      = pick_src_s & (~pick_src_s + NUM_CH'(1));
        gnt_idx_o  = CH_W'(oh_to_idx(MAX_CH'(gnt_o)));
    end

endmodule

// File: rtl/mc_rd_scheduler.sv
// Shares the latency-1 buffer read port among NUM_CH readers with round-robin
// plus burst hold, and routes each returned word to the channel that issued it.
module mc_rd_scheduler
    import mc_buf_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int WIDTH     = 32,
    parameter int BURST_LEN = 2,
    localparam int CH_W     = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sched_en,
    input  logic [NUM_CH-1:0] ch_req,
    input  logic [NUM_CH-1:0] ch_empty,
    output logic [NUM_CH-1:0] ch_gnt,
    output logic [NUM_CH-1:0] ch_rd_valid,
    output logic [WIDTH-1:0]  ch_rd_data,
    output logic              mem_rd_en,
    output logic [CH_W-1:0]   mem_rd_ch,
    input  logic              mem_rd_valid,
    input  logic [WIDTH-1:0]  mem_rd_data,
    output logic              err_protocol
);

    arb_state_t             state_q, state_d;
    logic [CH_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]        cur_ch_q, cur_ch_d;
    logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [CH_W-1:0]        tag_q, tag_d;
    logic                   tag_vld_q, tag_vld_d;
    logic                   err_q, err_d;

    logic [NUM_CH-1:0]      eligible_s;
    logic [NUM_CH-1:0]      arb_gnt_s;
    logic [CH_W-1:0]        arb_idx_s;
    logic [NUM_CH-1:0]      win_gnt_s;
    logic [CH_W-1:0]        win_idx_s;
    logic                   hold_s;
    logic                   any_gnt_s;
    logic                   gnt_live_s;

    assign eligible_s = {NUM_CH{sched_en}} & ch_req & ~ch_empty;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .eligible_i (eligible_s),
        .rr_ptr_i   (rr_ptr_q),
        .gnt_o      (arb_gnt_s),
        .gnt_idx_o  (arb_idx_s)
    );

    // Winner selection: an unfinished burst keeps the port, otherwise round-robin decides.
    always_comb begin
        win_gnt_s   = '0;
        win_idx_s   = cur_ch_q;
        rr_ptr_d    = rr_ptr_q;
        cur_ch_d    = cur_ch_q;
        burst_cnt_d = burst_cnt_q;
        hold_s      = (state_q == ARB_HOLD) && eligible_s[cur_ch_q];
        if (hold_s) begin
            win_gnt_s   = NUM_CH'(idx_to_oh(ch_idx_t'(cur_ch_q)));
            burst_cnt_d = burst_cnt_q + BURST_CNT_W'(1);
        end else if (|arb_gnt_s) begin
            win_gnt_s   = arb_gnt_s;
            win_idx_s   = arb_idx_s;
            cur_ch_d    = arb_idx_s;
            burst_cnt_d = BURST_CNT_W'(1);
            rr_ptr_d    = (arb_idx_s == CH_W'(NUM_CH - 1)) ? '0 : arb_idx_s + CH_W'(1);
        end else begin
            win_gnt_s   = '0;
        end
        any_gnt_s = |win_gnt_s;
        if (any_gnt_s && (burst_cnt_d < BURST_CNT_W'(BURST_LEN))) begin
            state_d = ARB_HOLD;
        end else begin
            state_d = ARB_IDLE;
        end
        tag_vld_d = any_gnt_s;
        tag_d     = any_gnt_s ? win_idx_s : tag_q;
        err_d     = err_q | (mem_rd_valid ^ tag_vld_q);
    end

    // Arbitration, return-tag and sticky error state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            cur_ch_q    <= '0;
            burst_cnt_q <= '0;
            tag_q       <= '0;
            tag_vld_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_ch_q    <= cur_ch_d;
            burst_cnt_q <= burst_cnt_d;
            tag_q       <= tag_d;
            tag_vld_q   <= tag_vld_d;
            err_q       <= err_d;
        end
    end

    // Grants are combinational, so they are masked while reset is held.
    assign gnt_live_s   = rst_n & any_gnt_s;
    assign ch_gnt       = win_gnt_s & {NUM_CH{rst_n}};
    assign mem_rd_en    = gnt_live_s;
    assign mem_rd_ch    = gnt_live_s ? win_idx_s : tag_q;
    assign ch_rd_valid  = (mem_rd_valid & tag_vld_q) ? NUM_CH'(idx_to_oh(ch_idx_t'(tag_q))) : '0;
    assign ch_rd_data   = mem_rd_data;
    assign err_protocol = err_q;

endmodule
